dht_uart_reporter: RTL and testbench
====================================

Name: dht_uart_reporter

Overview:
Downstream consumer of the DHT sensor top. It captures one completed reading: humidity and temperature bytes, parity-error flag and timeout flag. It converts each byte to three ASCII decimal digits with a sequential double-dabble converter, then streams a fixed 23-byte text frame to a byte-wide UART transmitter through a start/busy handshake. While a frame is being converted or sent, no new reading is accepted.

Parameters:
REPORT_ERRORS, 1, 1 = send frames whose status is parity error or timeout; 0 = discard them silently (no o_dropped).
FRAME_LEN, 23, bytes per frame; fixed by the format below and not meant to be overridden.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_valid  input  1  one-cycle pulse: reading complete, data inputs valid this cycle
i_humi_int  input  8  humidity integral byte
i_humi_dec  input  8  humidity decimal byte
i_temp_int  input  8  temperature integral byte
i_temp_dec  input  8  temperature decimal byte
i_error  input  1  parity mismatch for this reading
i_tout  input  1  sensor timeout for this reading
i_tx_busy  input  1  UART transmitter busy
o_tx_start  output  1  one-cycle pulse: o_tx_data is to be transmitted
o_tx_data  output  8  ASCII byte to transmit
o_busy  output  1  high in any state other than IDLE
o_dropped  output  1  one-cycle pulse: i_valid arrived while o_busy was high

Behaviour:
- Reset (asynchronous, any time, including mid-conversion or mid-send):
  - state goes to IDLE.
  - o_tx_start = 0, o_tx_data = 8'h00, o_busy = 0, o_dropped = 0.
  - All latched bytes, BCD digits and the byte index are cleared.
- Frame format, in byte order: 'H' ':' H2 H1 H0 '.' h2 h1 h0 ' ' 'T' ':' T2 T1 T0 '.' t2 t1 t0 ' ' S CR LF.
  - Each digit group is the 3-digit decimal (000-255) of the corresponding byte, ASCII = 8'h30 + BCD digit.
  - Status S: 'T' (8'h54) if i_tout; else 'E' (8'h45) if i_error; else 'K' (8'h4B). i_tout has priority over i_error.
- States: IDLE -> CONV -> SEND -> WAIT_TX -> (SEND | IDLE).
- IDLE:
  - When i_valid = 1, latch all inputs and compute status.
  - If REPORT_ERRORS = 0 and status is not 'K', stay in IDLE.
  - Otherwise go to CONV and assert o_busy from the next cycle.
- CONV:
  - Converts the four bytes in the order humi_int, humi_dec, temp_int, temp_dec.
  - Each byte takes 9 cycles: 1 load cycle plus 8 shift/add-3 cycles.
  - Total is exactly 36 cycles, then the block enters SEND.
- SEND:
  - When i_tx_busy = 0, drive o_tx_data = frame[idx] and pulse o_tx_start for exactly 1 cycle, then go to WAIT_TX.
  - If i_tx_busy = 1, hold with o_tx_start = 0 (stall for any duration).
- WAIT_TX:
  - i_tx_busy is ignored for the first cycle; the transmitter must raise busy the cycle after start.
  - After that, wait for i_tx_busy = 0, then idx++.
  - If idx was FRAME_LEN-1, go to IDLE; otherwise go to SEND.
- o_tx_data holds the last byte sent until the next start; it changes only when o_tx_start pulses.
- Latency: with i_tx_busy low, the first o_tx_start occurs 38 cycles after the i_valid cycle.
  - Breakdown: 1 latch cycle, 36 conversion cycles, 1 SEND cycle.
- i_valid while o_busy = 1: the reading is ignored, latched data is unchanged, and o_dropped pulses the next cycle.
- Only the i_valid cycle is sampled; data inputs may change freely at any other time.

Decomposition:
- Shared package:
  - ASCII constants: 'H', 'T', ':', '.', ' ', 'K', 'E', CR = 8'h0D, LF = 8'h0A.
  - FRAME_LEN.
  - State encoding.
- One natural sub-module: bin8_to_bcd_seq.
  - Interface: start, 8-bit in, done, and three 4-bit digits.
  - Sequential double-dabble with a fixed 9-cycle latency; instantiated once and reused for all four bytes.
- Frame byte selection is a combinational mux on idx inside the top.

Test Plan:
- Basic frame: i_valid with humi 45/0, temp 23/0, no error, tx model busy for 10 cycles per byte -> exactly 23 starts carrying "H:045.000 T:023.000 K\r\n"; first start at cycle +38.
- Parity error: i_error = 1 with humi 255/9, temp 0/7 -> "H:255.009 T:000.007 E\r\n". Rerun with REPORT_ERRORS = 0 -> no starts, o_busy stays 0.
- Timeout priority: i_tout = 1 and i_error = 1 together -> status byte is 8'h54 'T'.
- Drop: second i_valid pulse at cycle +50 of the first frame -> one o_dropped pulse; frame content is still the first reading.
- Stall: hold i_tx_busy = 1 for 200 cycles before byte 5 -> no start during the hold; byte 5 = '.' is sent after release and the frame completes.
- Reset mid-send: assert rst while idx = 12 -> all outputs 0 immediately. A new i_valid afterwards -> a full fresh frame starting with 'H'.

Source files
------------

// File: rtl/dht_uart_reporter_pkg.sv
// Shared constants, state encoding and BCD helpers
// for the DHT reading to UART text reporter.
package dht_uart_reporter_pkg;

  localparam int FRAME_LEN = 23;

  localparam logic [7:0] A_H   = 8'h48;
  localparam logic [7:0] A_T   = 8'h54;
  localparam logic [7:0] A_COL = 8'h3A;
  localparam logic [7:0] A_DOT = 8'h2E;
  localparam logic [7:0] A_SP  = 8'h20;
  localparam logic [7:0] A_K   = 8'h4B;
  localparam logic [7:0] A_E   = 8'h45;
  localparam logic [7:0] A_CR  = 8'h0D;
  localparam logic [7:0] A_LF  = 8'h0A;
  localparam logic [7:0] A_0   = 8'h30;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SEND,
    S_WAIT
  } state_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [11:0] bcd_adj(input logic [11:0] b);
    return {add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] d);
    return A_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/dht_uart_reporter_bcd.sv
// Sequential double-dabble: one load cycle, then
// eight shift/add-3 cycles; done pulses once after.
module bin8_to_bcd_seq
  import dht_uart_reporter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  logic [7:0]  sr;
  logic [11:0] bcd;
  logic [11:0] adj;
  logic [3:0]  cnt;

  always_comb adj = bcd_adj(bcd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr  <= bin;
        bcd <= '0;
        cnt <= 4'd8;
      end else if (cnt != 4'd0) begin
        {bcd, sr} <= {adj, sr} << 1;
        cnt       <= cnt - 4'd1;
        if (cnt == 4'd1) done <= 1'b1;
      end
    end
  end

  assign d2 = bcd[11:8];
  assign d1 = bcd[7:4];
  assign d0 = bcd[3:0];

endmodule

// File: rtl/dht_uart_reporter.sv
// Latches one DHT reading, converts it to decimal
// and streams a 23-byte ASCII frame to a UART.
module dht_uart_reporter #(
  parameter bit REPORT_ERRORS = 1'b1,
  parameter int FRAME_LEN = dht_uart_reporter_pkg::FRAME_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_humi_int,
  input  logic [7:0] i_humi_dec,
  input  logic [7:0] i_temp_int,
  input  logic [7:0] i_temp_dec,
  input  logic       i_error,
  input  logic       i_tout,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_dropped
);
  import dht_uart_reporter_pkg::*;

  localparam logic [4:0] LAST = 5'(FRAME_LEN - 1);

  state_t state, nxt;

  logic [7:0] hi_q, hd_q, ti_q, td_q, stat_q;
  logic [3:0][11:0] bcd_q;
  logic [3:0] step;
  logic [1:0] bsel, cap;
  logic [4:0] idx;
  logic       wt_first;
  logic       accept, send, adv;
  logic       cv_start, cv_done;
  logic [3:0] d2, d1, d0;
  logic [7:0] cv_bin, frame_b, stat_in;

  always_comb begin
    stat_in = A_K;
    if (i_tout)       stat_in = A_T;
    else if (i_error) stat_in = A_E;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    send   = 1'b0;
    adv    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_valid && (REPORT_ERRORS || stat_in == A_K)) begin
          accept = 1'b1;
          nxt    = S_CONV;
        end
      end
      S_CONV: begin
        if (bsel == 2'd3 && step == 4'd8) nxt = S_SEND;
      end
      S_SEND: begin
        if (!i_tx_busy) begin
          send = 1'b1;
          nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        // first WAIT cycle overlaps the start pulse
        if (!wt_first && !i_tx_busy) begin
          adv = 1'b1;
          nxt = (idx == LAST) ? S_IDLE : S_SEND;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign o_busy   = (state != S_IDLE);
  assign cv_start = (state == S_CONV) && (step == 4'd0);

  always_comb begin
    cv_bin = hi_q;
    unique case (bsel)
      2'd0: cv_bin = hi_q;
      2'd1: cv_bin = hd_q;
      2'd2: cv_bin = ti_q;
      2'd3: cv_bin = td_q;
      default: cv_bin = hi_q;
    endcase
  end

  bin8_to_bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (cv_start),
    .bin   (cv_bin),
    .done  (cv_done),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0)
  );

  always_comb begin
    frame_b = 8'h00;
    case (idx)
      5'd0:  frame_b = A_H;
      5'd1:  frame_b = A_COL;
      5'd2:  frame_b = asc(bcd_q[0][11:8]);
      5'd3:  frame_b = asc(bcd_q[0][7:4]);
      5'd4:  frame_b = asc(bcd_q[0][3:0]);
      5'd5:  frame_b = A_DOT;
      5'd6:  frame_b = asc(bcd_q[1][11:8]);
      5'd7:  frame_b = asc(bcd_q[1][7:4]);
      5'd8:  frame_b = asc(bcd_q[1][3:0]);
      5'd9:  frame_b = A_SP;
      5'd10: frame_b = A_T;
      5'd11: frame_b = A_COL;
      5'd12: frame_b = asc(bcd_q[2][11:8]);
      5'd13: frame_b = asc(bcd_q[2][7:4]);
      5'd14: frame_b = asc(bcd_q[2][3:0]);
      5'd15: frame_b = A_DOT;
      5'd16: frame_b = asc(bcd_q[3][11:8]);
      5'd17: frame_b = asc(bcd_q[3][7:4]);
      5'd18: frame_b = asc(bcd_q[3][3:0]);
      5'd19: frame_b = A_SP;
      5'd20: frame_b = stat_q;
      5'd21: frame_b = A_CR;
      5'd22: frame_b = A_LF;
      default: frame_b = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q       <= '0;
      hd_q       <= '0;
      ti_q       <= '0;
      td_q       <= '0;
      stat_q     <= '0;
      bcd_q      <= '0;
      step       <= '0;
      bsel       <= '0;
      cap        <= '0;
      idx        <= '0;
      wt_first   <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= 8'h00;
      o_dropped  <= 1'b0;
    end else begin
      o_dropped  <= i_valid && (state != S_IDLE);
      o_tx_start <= send;
      wt_first   <= send;
      if (send) o_tx_data <= frame_b;
      if (accept) begin
        hi_q   <= i_humi_int;
        hd_q   <= i_humi_dec;
        ti_q   <= i_temp_int;
        td_q   <= i_temp_dec;
        stat_q <= stat_in;
        step   <= '0;
        bsel   <= '0;
        cap    <= '0;
        idx    <= '0;
      end
      if (state == S_CONV) begin
        if (step == 4'd8) begin
          step <= '0;
          bsel <= bsel + 2'd1;
        end else begin
          step <= step + 4'd1;
        end
      end
      if (cv_done) begin
        bcd_q[cap] <= {d2, d1, d0};
        cap        <= cap + 2'd1;
      end
      if (adv) idx <= idx + 5'd1;
    end
  end

endmodule

// File: tb/tb_dht_uart_reporter.sv
// Scoreboard bench: stimulus queues expected frame
// bytes, a monitor checks each transmitted byte.
module tb_dht_uart_reporter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] hi = 8'h00, hd = 8'h00, ti = 8'h00, td = 8'h00;
  logic       er = 1'b0, to = 1'b0;
  logic       txb = 1'b0, stall = 1'b0;
  logic       i_tx_busy;
  logic       o_tx_start, o_busy, o_dropped;
  logic [7:0] o_tx_data;
  logic       r0_start, r0_busy, r0_dropped;
  logic [7:0] r0_data;

  assign i_tx_busy = txb | stall;

  always #5 clk = ~clk;

  dht_uart_reporter dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_humi_int (hi),
    .i_humi_dec (hd),
    .i_temp_int (ti),
    .i_temp_dec (td),
    .i_error    (er),
    .i_tout     (to),
    .i_tx_busy  (i_tx_busy),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_busy     (o_busy),
    .o_dropped  (o_dropped)
  );

  dht_uart_reporter #(.REPORT_ERRORS(1'b0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_humi_int (hi),
    .i_humi_dec (hd),
    .i_temp_int (ti),
    .i_temp_dec (td),
    .i_error    (er),
    .i_tout     (to),
    .i_tx_busy  (i_tx_busy),
    .o_tx_start (r0_start),
    .o_tx_data  (r0_data),
    .o_busy     (r0_busy),
    .o_dropped  (r0_dropped)
  );

  int cyc = 0;
  int vcyc = 0;
  int vecs = 0;
  int errs = 0;
  int n_starts = 0;
  int n_drops = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // UART model: busy for 10 cycles after each start
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (o_tx_start) begin
        txb = 1'b1;
        repeat (10) @(posedge clk);
        #1 txb = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (o_tx_start) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL tx_byte got=%0h expected=none", o_tx_data);
      end else begin
        check("tx_byte", {24'h0, o_tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (o_dropped) n_drops++;
  end

  task automatic push_frame(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d,
                       input logic e, input logic t);
    @(negedge clk);
    hi = a; hd = b; ti = c; td = d; er = e; to = t;
    i_valid = 1'b1;
    vcyc = cyc;
    @(negedge clk);
    i_valid = 1'b0;
    hi = 8'h5A; hd = 8'hA5; ti = 8'h3C; td = 8'hC3;
    er = 1'b1; to = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 2000 && o_busy; k++) @(negedge clk);
    check(nm, {31'h0, o_busy}, 32'h0);
    check({nm, "_queue"}, exp_q.size(), 32'h0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_start"}, {31'h0, o_tx_start}, 32'h0);
    check({nm, "_data"}, {24'h0, o_tx_data}, 32'h0);
    check({nm, "_busy"}, {31'h0, o_busy}, 32'h0);
    check({nm, "_drop"}, {31'h0, o_dropped}, 32'h0);
  endtask

  initial begin
    int base;
    int s5;
    int d0;
    logic bad0;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    push_frame("H:045.000 T:023.000 K");
    pulse(8'd45, 8'd0, 8'd23, 8'd0, 1'b0, 1'b0);
    er = 1'b0; to = 1'b0;
    check("busy_after_valid", {31'h0, o_busy}, 32'h1);
    for (int k = 0; k < 80 && !o_tx_start; k++) @(negedge clk);
    check("first_latency", cyc - vcyc, 32'd38);
    wait_idle("basic_idle");
    repeat (30) @(negedge clk);

    push_frame("H:255.009 T:000.007 E");
    pulse(8'd255, 8'd9, 8'd0, 8'd7, 1'b1, 1'b0);
    bad0 = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (r0_busy || r0_start) bad0 = 1'b1;
    end
    check("noreport_quiet", {31'h0, bad0}, 32'h0);
    wait_idle("parity_idle");
    repeat (5) @(negedge clk);

    push_frame("H:100.050 T:012.003 T");
    pulse(8'd100, 8'd50, 8'd12, 8'd3, 1'b1, 1'b1);
    wait_idle("tout_idle");
    repeat (5) @(negedge clk);

    d0 = n_drops;
    push_frame("H:007.008 T:099.001 K");
    pulse(8'd7, 8'd8, 8'd99, 8'd1, 1'b0, 1'b0);
    repeat (48) @(negedge clk);
    pulse(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0);
    check("dropped_pulse", {31'h0, o_dropped}, 32'h1);
    @(negedge clk);
    check("dropped_once", {31'h0, o_dropped}, 32'h0);
    wait_idle("drop_idle");
    check("drop_count", n_drops - d0, 32'd1);
    repeat (5) @(negedge clk);

    base = n_starts;
    push_frame("H:128.064 T:032.016 K");
    pulse(8'd128, 8'd64, 8'd32, 8'd16, 1'b0, 1'b0);
    for (int k = 0; k < 2000 && n_starts - base < 5; k++)
      @(negedge clk);
    check("stall_reach5", n_starts - base, 32'd5);
    stall = 1'b1;
    s5 = n_starts;
    repeat (200) @(negedge clk);
    check("stall_hold", n_starts - s5, 32'd0);
    stall = 1'b0;
    wait_idle("stall_idle");
    repeat (5) @(negedge clk);

    base = n_starts;
    push_frame("H:001.002 T:003.004 K");
    pulse(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0);
    for (int k = 0; k < 2000 && n_starts - base < 12; k++)
      @(negedge clk);
    check("reach12", n_starts - base, 32'd12);
    #2 rst = 1'b1;
    #1 check_zero("midsend_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    push_frame("H:200.100 T:050.025 K");
    pulse(8'd200, 8'd100, 8'd50, 8'd25, 1'b0, 1'b0);
    wait_idle("fresh_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
